// File: rtl/history_snapshot_reader_if.sv
// Streaming port of the history snapshot reader.
// The master drives one history entry per beat (m_data), the slot it came
// from (m_idx) and an end-of-snapshot marker (m_last), qualified by m_valid.
// The slave accepts a beat with m_ready.
//   m_data   master->slave  DATA_W  streamed history entry
//   m_idx    master->slave  2       slot index of m_data (0 = newest)
//   m_last   master->slave  1       final beat of the snapshot
//   m_valid  master->slave  1       beat valid
//   m_ready  slave->master  1       consumer ready
interface history_snapshot_reader_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_idx;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_idx,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_idx,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/history_snapshot_reader.sv
// Reader end of a 4-entry unique-value history (slot 0 = newest).
// A request taken in IDLE freezes the four slots and their valid flags, then
// the valid entries are streamed one per beat over the master port, skipping
// invalid slots. ORDER=0 emits slot 0..3, ORDER=1 emits slot 3..0.
// Ports:
//   clk_in          clock, rising edge
//   reset_in        asynchronous active-high reset
//   in_0..in_3      history slot data
//   in_valid_0..3   history slot valid flags
//   rd_req_in       read request, only looked at in IDLE
//   busy_out        high while a snapshot is being streamed
//   empty_out       one-cycle pulse: request taken with no valid slot
//   m               streaming master port (data/idx/last/valid, ready)
// Every output comes straight from a register.
module history_snapshot_reader #(
  parameter int DATA_W = 8,
  parameter int ORDER  = 0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  input  logic              rd_req_in,
  output logic              busy_out,
  output logic              empty_out,
  history_snapshot_reader_if.master m
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] snap_q [4];
  logic [DATA_W-1:0] snap_d [4];
  // Valid slots of the snapshot that are still to be emitted after the
  // beat currently presented.
  logic [3:0]        pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              empty_q, empty_d;

  logic [DATA_W-1:0] in_arr [4];
  logic [3:0]        vin;

  assign in_arr[0] = in_0;
  assign in_arr[1] = in_1;
  assign in_arr[2] = in_2;
  assign in_arr[3] = in_3;
  assign vin       = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  // First set slot of mask in emit order: lowest index for ORDER=0,
  // highest index for ORDER=1.
  function automatic logic [1:0] pick(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    if (ORDER == 0) begin
      for (int i = 3; i >= 0; i--)
        if (mask[i]) r = 2'(i);
    end else begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    empty_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_req_in) begin
          snap_d = in_arr;
          if (|vin) begin
            // First beat is built from the live inputs so it can be
            // presented on the cycle right after the request.
            state_d = SEND;
            idx_d   = pick(vin);
            data_d  = in_arr[idx_d];
            pend_d  = vin & ~onehot(idx_d);
            last_d  = (pend_d == 4'd0);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            pend_d  = 4'd0;
            empty_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (valid_q && m.m_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = pick(pend_q);
            data_d = snap_q[idx_d];
            pend_d = pend_q & ~onehot(idx_d);
            last_d = (pend_d == 4'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      pend_q  <= 4'd0;
      data_q  <= '0;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      empty_q <= empty_d;
    end
  end

  assign m.m_data  = data_q;
  assign m.m_idx   = idx_q;
  assign m.m_last  = last_q;
  assign m.m_valid = valid_q;
  assign busy_out  = busy_q;
  assign empty_out = empty_q;

endmodule

// File: tb/tb_history_snapshot_reader.sv
module tb_history_snapshot_reader;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] d0, d1, d2, d3;
  logic              v0, v1, v2, v3;
  logic              req0, req1;
  logic              busy0, busy1, empty0, empty1;

  int n_tests = 0;
  int n_fail  = 0;

  history_snapshot_reader_if #(.DATA_W(DATA_W)) if0 ();
  history_snapshot_reader_if #(.DATA_W(DATA_W)) if1 ();

  history_snapshot_reader #(.DATA_W(DATA_W), .ORDER(0)) dut0 (
    .clk_in(clk), .reset_in(rst),
    .in_0(d0), .in_1(d1), .in_2(d2), .in_3(d3),
    .in_valid_0(v0), .in_valid_1(v1), .in_valid_2(v2), .in_valid_3(v3),
    .rd_req_in(req0), .busy_out(busy0), .empty_out(empty0),
    .m(if0.master)
  );

  history_snapshot_reader #(.DATA_W(DATA_W), .ORDER(1)) dut1 (
    .clk_in(clk), .reset_in(rst),
    .in_0(d0), .in_1(d1), .in_2(d2), .in_3(d3),
    .in_valid_0(v0), .in_valid_1(v1), .in_valid_2(v2), .in_valid_3(v3),
    .rd_req_in(req1), .busy_out(busy1), .empty_out(empty1),
    .m(if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input string tag, input logic [1:0] idx, input logic [7:0] data,
                       input logic last);
    check({tag, ".valid"}, 32'(if0.m_valid), 32'd1);
    check({tag, ".busy"},  32'(busy0),       32'd1);
    check({tag, ".idx"},   32'(if0.m_idx),   32'(idx));
    check({tag, ".data"},  32'(if0.m_data),  32'(data));
    check({tag, ".last"},  32'(if0.m_last),  32'(last));
  endtask

  task automatic idle0(input string tag);
    check({tag, ".valid"}, 32'(if0.m_valid), 32'd0);
    check({tag, ".busy"},  32'(busy0),       32'd0);
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] e, input logic [3:0] vm);
    d0 = a; d1 = b; d2 = c; d3 = e;
    {v3, v2, v1, v0} = vm;
  endtask

  task automatic pulse_req0();
    req0 = 1'b1;
    step();
    req0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    if0.m_ready = 1'b1; if1.m_ready = 1'b1;
    set_in(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    #12;
    // Reset state
    check("rst.valid", 32'(if0.m_valid), 32'd0);
    check("rst.busy",  32'(busy0),       32'd0);
    check("rst.empty", 32'(empty0),      32'd0);
    check("rst.data",  32'(if0.m_data),  32'd0);
    check("rst.idx",   32'(if0.m_idx),   32'd0);
    check("rst.last",  32'(if0.m_last),  32'd0);
    rst = 1'b0;
    step();

    // 1: all valid, newest first
    set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    pulse_req0();
    beat0("t1.b0", 2'd0, 8'h11, 1'b0); step();
    beat0("t1.b1", 2'd1, 8'h22, 1'b0); step();
    beat0("t1.b2", 2'd2, 8'h33, 1'b0); step();
    beat0("t1.b3", 2'd3, 8'h44, 1'b1); step();
    idle0("t1.end");

    // 2: two valid slots; request right after previous stream ended
    set_in(8'hA5, 8'h5A, 8'h77, 8'h88, 4'b0011);
    pulse_req0();
    beat0("t2.b0", 2'd0, 8'hA5, 1'b0); step();
    beat0("t2.b1", 2'd1, 8'h5A, 1'b1); step();
    idle0("t2.end");

    // 3: nothing valid -> single empty pulse
    set_in(8'h12, 8'h34, 8'h56, 8'h78, 4'b0000);
    pulse_req0();
    check("t3.empty", 32'(empty0), 32'd1);
    idle0("t3.n1");
    step();
    check("t3.empty_drop", 32'(empty0), 32'd0);
    idle0("t3.n2");

    // 4: back-pressure on beat idx1
    set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    pulse_req0();
    beat0("t4.b0", 2'd0, 8'h11, 1'b0);
    step();
    if0.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat0($sformatf("t4.hold%0d", i), 2'd1, 8'h22, 1'b0);
      step();
    end
    beat0("t4.hold3", 2'd1, 8'h22, 1'b0);
    if0.m_ready = 1'b1;
    step();
    beat0("t4.b2", 2'd2, 8'h33, 1'b0); step();
    beat0("t4.b3", 2'd3, 8'h44, 1'b1); step();
    idle0("t4.end");

    // 5: ORDER=1, slots 0 and 2 valid -> idx2 then idx0
    set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b0101);
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    check("t5.b0.valid", 32'(if1.m_valid), 32'd1);
    check("t5.b0.idx",   32'(if1.m_idx),   32'd2);
    check("t5.b0.data",  32'(if1.m_data),  32'h33);
    check("t5.b0.last",  32'(if1.m_last),  32'd0);
    step();
    check("t5.b1.idx",   32'(if1.m_idx),   32'd0);
    check("t5.b1.data",  32'(if1.m_data),  32'h11);
    check("t5.b1.last",  32'(if1.m_last),  32'd1);
    step();
    check("t5.end.valid", 32'(if1.m_valid), 32'd0);
    check("t5.end.busy",  32'(busy1),       32'd0);

    // 6: input changes and a new request mid-stream are ignored
    set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    pulse_req0();
    beat0("t6.b0", 2'd0, 8'h11, 1'b0);
    set_in(8'hEE, 8'hDD, 8'hCC, 8'hBB, 4'b0001);
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    beat0("t6.b1", 2'd1, 8'h22, 1'b0); step();
    beat0("t6.b2", 2'd2, 8'h33, 1'b0); step();
    beat0("t6.b3", 2'd3, 8'h44, 1'b1); step();
    idle0("t6.end");
    step();
    idle0("t6.noq");

    // 7: reset during beat 2 aborts, later request starts over
    set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    pulse_req0();
    step();
    beat0("t7.b1", 2'd1, 8'h22, 1'b0);
    rst = 1'b1;
    #1;
    check("t7.rst.valid", 32'(if0.m_valid), 32'd0);
    check("t7.rst.busy",  32'(busy0),       32'd0);
    check("t7.rst.data",  32'(if0.m_data),  32'd0);
    check("t7.rst.idx",   32'(if0.m_idx),   32'd0);
    check("t7.rst.last",  32'(if0.m_last),  32'd0);
    step();
    rst = 1'b0;
    step();
    idle0("t7.post");
    pulse_req0();
    beat0("t7.r0", 2'd0, 8'h11, 1'b0); step();
    beat0("t7.r1", 2'd1, 8'h22, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
